// File: rtl/map_sst_seq.sv
// map_sst_seq: walks a mapper's save-state register window and dumps or restores it over byte streams.
// Optional CRC-8 trailer on both streams is enabled by defining SST_SEQ_CRC_EN.
module map_sst_seq #(
    parameter int REG_CNT  = 128,
    parameter int IDX_ADDR = 127,
    parameter int RD_LAT   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sys_frozen,
    input  logic       cmd_dump,
    input  logic       cmd_load,
    input  logic       cmd_abort,
    input  logic [7:0] map_idx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic       sst_we,
    output logic [7:0] sst_do,
    input  logic [7:0] sst_di,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    // Both byte streams are valid/ready: a byte moves on a clk edge where valid && ready are both
    // high; the sender keeps data stable and valid asserted until that edge.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D_WAIT  = 3'd1,
        D_SEND  = 3'd2,
        L_RECV  = 3'd3,
        L_WRITE = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [7:0] LAST_ADDR = 8'(REG_CNT - 1);
    localparam logic [7:0] IDX       = 8'(IDX_ADDR);
    localparam logic [2:0] LAT       = 3'(RD_LAT);

    state_t     state, state_nxt;
    logic [7:0] addr_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] txd_nxt;
    logic [7:0] sdo_nxt;
    logic       err_nxt;

`ifdef SST_SEQ_CRC_EN
    logic [7:0] crc, crc_nxt;
    logic       crc_ph, crc_ph_nxt;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sst_addr <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            sst_do   <= '0;
            err      <= 1'b0;
`ifdef SST_SEQ_CRC_EN
            crc      <= '0;
            crc_ph   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            sst_addr <= addr_nxt;
            cnt      <= cnt_nxt;
            tx_data  <= txd_nxt;
            sst_do   <= sdo_nxt;
            err      <= err_nxt;
`ifdef SST_SEQ_CRC_EN
            crc      <= crc_nxt;
            crc_ph   <= crc_ph_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = sst_addr;
        cnt_nxt   = cnt;
        txd_nxt   = tx_data;
        sdo_nxt   = sst_do;
        err_nxt   = err;
`ifdef SST_SEQ_CRC_EN
        crc_nxt    = crc;
        crc_ph_nxt = crc_ph;
`endif
        busy     = 1'b0;
        done     = 1'b0;
        sst_act  = 1'b0;
        sst_we   = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;

        case (state)
            IDLE: begin
                if ((cmd_dump || cmd_load) && (cmd_dump == cmd_load || !sys_frozen)) begin
                    err_nxt = 1'b1;
                end else if (cmd_dump || cmd_load) begin
                    err_nxt   = 1'b0;
                    addr_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = cmd_dump ? D_WAIT : L_RECV;
`ifdef SST_SEQ_CRC_EN
                    crc_nxt    = '0;
                    crc_ph_nxt = 1'b0;
`endif
                end
            end
            D_WAIT: begin
                busy    = 1'b1;
                sst_act = 1'b1;
                // cnt reaches LAT on the first cycle the mapper read data is valid
                if (cnt == LAT) begin
                    txd_nxt   = sst_di;
                    state_nxt = D_SEND;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            D_SEND: begin
                busy     = 1'b1;
                sst_act  = 1'b1;
                tx_valid = 1'b1;
                if (tx_ready) begin
`ifdef SST_SEQ_CRC_EN
                    crc_nxt = crc8(crc, tx_data);
`endif
                    if (sst_addr != LAST_ADDR) begin
                        addr_nxt  = sst_addr + 8'd1;
                        cnt_nxt   = '0;
                        state_nxt = D_WAIT;
`ifdef SST_SEQ_CRC_EN
                    end else if (!crc_ph) begin
                        txd_nxt    = crc8(crc, tx_data);
                        crc_ph_nxt = 1'b1;
`endif
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            L_RECV: begin
                busy     = 1'b1;
                sst_act  = 1'b1;
                rx_ready = 1'b1;
                if (rx_valid) begin
`ifdef SST_SEQ_CRC_EN
                    if (crc_ph) begin
                        if (rx_data != crc) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = FIN;
                        end
                    end else begin
                        sdo_nxt   = rx_data;
                        crc_nxt   = crc8(crc, rx_data);
                        state_nxt = L_WRITE;
                    end
`else
                    sdo_nxt   = rx_data;
                    state_nxt = L_WRITE;
`endif
                end
            end
            L_WRITE: begin
                busy    = 1'b1;
                sst_act = 1'b1;
                // the index register is read-only: it is compared, never written
                sst_we  = (sst_addr != IDX);
                if (sst_addr == IDX && sst_do != map_idx) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (sst_addr == LAST_ADDR) begin
`ifdef SST_SEQ_CRC_EN
                    crc_ph_nxt = 1'b1;
                    state_nxt  = L_RECV;
`else
                    state_nxt = FIN;
`endif
                end else begin
                    addr_nxt  = sst_addr + 8'd1;
                    state_nxt = L_RECV;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // losing the freeze is treated exactly like an explicit abort
        if (state != IDLE && (cmd_abort || !sys_frozen)) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end
    end

endmodule

// File: tb/tb_map_sst_seq.sv
// Bench for map_sst_seq: command table, scripted dump/load/abort runs and randomized streams
// scored against a model of the mapper window (byte at address a reads back as a ^ 0x5A).
module tb_map_sst_seq;

    localparam int         REG_CNT  = 128;
    localparam int         IDX_ADDR = 127;
    localparam int         RD_LAT   = 1;
    localparam logic [7:0] MAP_IDX  = 8'h04;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sys_frozen = 1'b1;
    logic       cmd_dump = 1'b0;
    logic       cmd_load = 1'b0;
    logic       cmd_abort = 1'b0;
    logic [7:0] map_idx = MAP_IDX;
    logic       busy, done, err, sst_act, sst_we;
    logic [7:0] sst_addr, sst_do;
    logic [7:0] sst_di = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] wr_q[$];
    int          done_cnt = 0;

    typedef struct {
        logic dump, load, frozen;
        logic exp_busy, exp_err, exp_rx_ready, exp_sst_act;
    } cmd_vec_t;
    cmd_vec_t vecs[7];

    // clock / reset
    always #5 clk = ~clk;

    map_sst_seq #(.REG_CNT(REG_CNT), .IDX_ADDR(IDX_ADDR), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .sys_frozen(sys_frozen),
        .cmd_dump(cmd_dump), .cmd_load(cmd_load), .cmd_abort(cmd_abort), .map_idx(map_idx),
        .busy(busy), .done(done), .err(err), .sst_act(sst_act),
        .sst_addr(sst_addr), .sst_we(sst_we), .sst_do(sst_do), .sst_di(sst_di),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    // mapper model: registered read port (one cycle latency), write log, done counter
    always @(posedge clk) sst_di <= sst_addr ^ 8'h5A;

    always @(negedge clk) begin
        if (sst_we) wr_q.push_back({sst_addr, sst_do});
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_dump = 1'b0; cmd_load = 1'b0; cmd_abort = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; sys_frozen = 1'b1; map_idx = MAP_IDX;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [30:0] all_outs();
        return {busy, done, err, sst_act, sst_addr, sst_we, sst_do, tx_data, tx_valid, rx_ready};
    endfunction

    // ready_mode 0: always ready, 1: ready one cycle in three, 2: random. abort_at < 0: no abort
    task automatic run_dump(input int ready_mode, input int abort_at, output int n_xfer, output int cycles);
        logic       stall;
        logic [7:0] held;
        exp_q.delete();
        for (int a = 0; a < REG_CNT; a++) exp_q.push_back(8'(a) ^ 8'h5A);
        n_xfer = 0; cycles = 0; stall = 1'b0; held = 8'h00;
        cmd_dump = 1'b1;
        tick();
        cmd_dump = 1'b0;
        while (busy && cycles < 5000) begin
            if (stall) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_data", tx_data, held);
            end
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cycles % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            cmd_abort = (abort_at >= 0 && n_xfer == abort_at && tx_valid);
            if (cmd_abort) tx_ready = 1'b0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) check("tx_extra_byte", 1, 0);
                else check("tx_byte", tx_data, exp_q.pop_front());
                n_xfer++;
            end
            stall = tx_valid && !tx_ready && !cmd_abort;
            held  = tx_data;
            tick();
            cycles++;
            cmd_abort = 1'b0;
        end
        tx_ready = 1'b0;
        if (cycles >= 5000) check("dump_timeout", 1, 0);
    endtask

    task automatic run_load(input logic rand_data, input logic match, input int valid_mode, input int drop_at);
        logic [7:0]  send_q[$];
        logic [15:0] wexp[$];
        logic [7:0]  b;
        logic        exp_done;
        int          wbase, dbase, cycles, n_acc, exp_acc;
        for (int a = 0; a < REG_CNT; a++) begin
            if (a == IDX_ADDR) b = match ? MAP_IDX : MAP_IDX + 8'd1;
            else b = rand_data ? 8'($urandom) : 8'(a);
            send_q.push_back(b);
        end
        // expected write log: every non-index address in order, cut short by a drop or a bad index
        exp_done = 1'b1;
        for (int a = 0; a < REG_CNT; a++) begin
            if (drop_at >= 0 && a == drop_at) begin exp_done = 1'b0; break; end
            if (a == IDX_ADDR) begin
                if (!match) begin exp_done = 1'b0; break; end
            end else begin
                wexp.push_back({8'(a), send_q[a]});
            end
        end
        exp_acc = (drop_at >= 0) ? drop_at : REG_CNT;
        wbase = wr_q.size(); dbase = done_cnt; cycles = 0; n_acc = 0;
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        while (busy && cycles < 5000) begin
            rx_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (send_q.size() == 0) rx_valid = 1'b0;
            if (drop_at >= 0 && n_acc == drop_at && rx_ready) begin
                sys_frozen = 1'b0;
                rx_valid   = 1'b0;
            end
            rx_data = rx_valid ? send_q[0] : 8'($urandom);
            if (rx_valid && rx_ready) begin
                void'(send_q.pop_front());
                n_acc++;
            end
            tick();
            cycles++;
        end
        if (cycles >= 5000) check("load_timeout", 1, 0);
        if (exp_done) check("load_done_now", done, 1);
        rx_valid = 1'b0; sys_frozen = 1'b1;
        tick();
        check("load_accepted", n_acc, exp_acc);
        check("load_wr_cnt", wr_q.size() - wbase, wexp.size());
        for (int i = 0; i < wexp.size() && wbase + i < wr_q.size(); i++)
            check($sformatf("load_wr%0d", i), wr_q[wbase + i], wexp[i]);
        check("load_done_cnt", done_cnt - dbase, exp_done ? 1 : 0);
        check("load_err", err, !exp_done);
        check("load_busy_after", busy, 0);
        check("load_act_after", sst_act, 0);
        check("load_rx_ready_after", rx_ready, 0);
    endtask

    initial begin
        int n, cyc, dbase;
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        #1;
        do_reset();
        check("reset_outputs", all_outs(), 0);

        // command table, each entry from a fresh reset
        for (int i = 0; i < 7; i++) begin
            do_reset();
            sys_frozen = vecs[i].frozen;
            cmd_dump   = vecs[i].dump;
            cmd_load   = vecs[i].load;
            tick();
            cmd_dump = 1'b0; cmd_load = 1'b0;
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_rx_ready", i), rx_ready, vecs[i].exp_rx_ready);
            check($sformatf("vec%0d_sst_act", i), sst_act, vecs[i].exp_sst_act);
            if (vecs[i].exp_busy) check($sformatf("vec%0d_addr0", i), sst_addr, 0);
            sys_frozen = 1'b1;
        end
        do_reset();

        // full-rate dump: RD_LAT+2 cycles per byte
        dbase = done_cnt;
        run_dump(0, -1, n, cyc);
        check("dump_done_now", done, 1);
        check("dump_latency", cyc, REG_CNT * (RD_LAT + 2));
        tick();
        check("dump_xfers", n, REG_CNT);
        check("dump_done_cnt", done_cnt - dbase, 1);
        check("dump_err", err, 0);
        check("dump_busy_after", busy, 0);
        check("dump_q_empty", exp_q.size(), 0);

        // throttled and random-ready dumps
        for (int m = 1; m <= 2; m++) begin
            dbase = done_cnt;
            run_dump(m, -1, n, cyc);
            tick();
            check($sformatf("dump_m%0d_xfers", m), n, REG_CNT);
            check($sformatf("dump_m%0d_done_cnt", m), done_cnt - dbase, 1);
            check($sformatf("dump_m%0d_err", m), err, 0);
        end

        // loads: ramp with good index, ramp with bad index, random data and pacing
        run_load(1'b0, 1'b1, 0, -1);
        run_load(1'b0, 1'b0, 0, -1);
        run_load(1'b1, 1'b1, 1, -1);
        run_load(1'b1, 1'b1, 1, -1);

        // abort a dump at byte 40
        dbase = done_cnt;
        run_dump(0, 40, n, cyc);
        check("abort_xfers", n, 40);
        check("abort_busy", busy, 0);
        check("abort_act", sst_act, 0);
        check("abort_err", err, 1);
        check("abort_tx_valid", tx_valid, 0);
        tick();
        check("abort_no_done", done_cnt - dbase, 0);

        // next dump start clears err; a load command while busy is ignored
        cmd_dump = 1'b1;
        tick();
        cmd_dump = 1'b0;
        check("restart_err_clear", err, 0);
        check("restart_busy", busy, 1);
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        check("ignore_busy", busy, 1);
        check("ignore_rx_ready", rx_ready, 0);
        check("ignore_err", err, 0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("abort2_err", err, 1);
        check("abort2_busy", busy, 0);

        // freeze lost at byte 10 of a load
        run_load(1'b1, 1'b1, 0, 10);

        // async reset in the middle of a load
        rx_data = 8'hA5; rx_valid = 1'b1;
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        repeat (31) tick();
        check("midload_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midload_reset_outputs", all_outs(), 0);
        rx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
